// File: rtl/duty_trace_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : duty_trace_sequencer
// Description : Record / playback / clear sequencer for the duty-cycle trace
//               RAM (separate X and Y arrays, 2^AW words of DW bits). Owns all
//               RAM addressing and drives registered DC_X/DC_Y to the PWM.
//               Optional feature macro: PLAY_ONESHOT_EN (play the trace once,
//               then return to IDLE instead of looping).
// Revision    : 1.0 - initial release
// ============================================================================
module duty_trace_sequencer #(
    parameter int AW       = 8,
    parameter int DW       = 6,
    parameter int STEP_DIV = 4096
) (
    input  logic          sysclk,
    input  logic          Reset_Sw,
    input  logic          Storage_Sw,
    input  logic          Play_Sw,
    input  logic          Clear_Sw,
    input  logic          Bt_Any,
    input  logic [DW-1:0] Duty_X,
    input  logic [DW-1:0] Duty_Y,
    input  logic [DW-1:0] Rd_X,
    input  logic [DW-1:0] Rd_Y,
    output logic          Wr_En,
    output logic [AW-1:0] Wr_Addr,
    output logic [DW-1:0] Wr_X,
    output logic [DW-1:0] Wr_Y,
    output logic [AW-1:0] Rd_Addr,
    output logic [DW-1:0] DC_X,
    output logic [DW-1:0] DC_Y,
    output logic [AW:0]   Count,
    output logic          Full,
    output logic          Playing,
    output logic          Busy
);

    localparam int            DIVW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIVW-1:0] C_LAST_DIV  = DIVW'(STEP_DIV - 1);
    localparam logic [AW:0]   C_DEPTH     = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] C_LAST_ADDR = {AW{1'b1}};

`ifdef PLAY_ONESHOT_EN
    localparam logic C_ONESHOT = 1'b1;
`else
    localparam logic C_ONESHOT = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    state_t          state_q;
    logic            bt_q;
    logic            clr_q;
    logic            clr_pend_q;   // clear edge seen while leaving RECORD/PLAY
    logic            done_q;       // one-shot finished; wait for Play_Sw low
    logic [1:0]      chg_q;        // read-address change pipeline (RAM + out reg)
    logic [DIVW-1:0] div_q;
    logic [AW:0]     count_q;
    logic            wr_en_q;
    logic [AW-1:0]   wr_addr_q;
    logic [DW-1:0]   wr_x_q;
    logic [DW-1:0]   wr_y_q;
    logic [AW-1:0]   rd_addr_q;    // doubles as the playback pointer
    logic [DW-1:0]   dc_x_q;
    logic [DW-1:0]   dc_y_q;
    logic            playing_q;
    logic            busy_q;

    logic            bt_evt;
    logic            clr_evt;
    logic            play_req;
    logic            full;
    logic [AW:0]     last_idx;
    logic            at_last;
    logic            div_tc;

    // Event detection, request qualification and playback terminal conditions
    assign bt_evt   = Bt_Any & ~bt_q;
    assign clr_evt  = Clear_Sw & ~clr_q;
    assign play_req = Play_Sw & ~done_q;
    assign full     = (count_q == C_DEPTH);
    assign last_idx = count_q - (AW+1)'(1);
    assign at_last  = ({1'b0, rd_addr_q} == last_idx);
    assign div_tc   = (div_q == C_LAST_DIV);

    // Mode sequencer: state, RAM addressing, counters and registered outputs
    always_ff @(posedge sysclk or posedge Reset_Sw) begin
        if (Reset_Sw) begin
            state_q    <= ST_IDLE;
            bt_q       <= 1'b0;
            clr_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            done_q     <= 1'b0;
            chg_q      <= 2'b00;
            div_q      <= '0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            rd_addr_q  <= '0;
            dc_x_q     <= '0;
            dc_y_q     <= '0;
            playing_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            bt_q    <= Bt_Any;
            clr_q   <= Clear_Sw;
            wr_en_q <= 1'b0;
            chg_q   <= {chg_q[0], 1'b0};
            if (!Play_Sw) begin
                done_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (clr_evt || clr_pend_q) begin
                        state_q    <= ST_CLEAR;
                        clr_pend_q <= 1'b0;
                        busy_q     <= 1'b1;
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= '0;
                        wr_x_q     <= '0;
                        wr_y_q     <= '0;
                        count_q    <= '0;
                        dc_x_q     <= '0;
                        dc_y_q     <= '0;
                        chg_q      <= 2'b00;
                    end else if (play_req) begin
                        state_q   <= ST_PLAY;
                        playing_q <= 1'b1;
                        rd_addr_q <= '0;
                        div_q     <= '0;
                        chg_q     <= 2'b01;
                    end else if (Storage_Sw) begin
                        state_q <= ST_RECORD;
                    end
                end

                ST_RECORD: begin
                    if (clr_evt) begin
                        state_q    <= ST_IDLE;
                        clr_pend_q <= 1'b1;
                    end else if (play_req) begin
                        state_q   <= ST_PLAY;
                        playing_q <= 1'b1;
                        rd_addr_q <= '0;
                        div_q     <= '0;
                        chg_q     <= 2'b01;
                    end else if (!Storage_Sw) begin
                        state_q <= ST_IDLE;
                    end else if (bt_evt && !full) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= count_q[AW-1:0];
                        wr_x_q    <= Duty_X;
                        wr_y_q    <= Duty_Y;
                        count_q   <= count_q + (AW+1)'(1);
                    end
                end

                ST_PLAY: begin
                    if (clr_evt) begin
                        state_q    <= ST_IDLE;
                        clr_pend_q <= 1'b1;
                        playing_q  <= 1'b0;
                        chg_q      <= 2'b00;
                    end else if (!Play_Sw) begin
                        state_q   <= ST_IDLE;
                        playing_q <= 1'b0;
                        chg_q     <= 2'b00;
                    end else if (count_q == '0) begin
                        // Nothing recorded: park at entry 0 and output zero duty
                        rd_addr_q <= '0;
                        div_q     <= '0;
                        dc_x_q    <= '0;
                        dc_y_q    <= '0;
                    end else begin
                        if (chg_q[1]) begin
                            dc_x_q <= Rd_X;
                            dc_y_q <= Rd_Y;
                        end
                        if (div_tc) begin
                            div_q <= '0;
                            if (at_last) begin
                                if (C_ONESHOT) begin
                                    state_q   <= ST_IDLE;
                                    playing_q <= 1'b0;
                                    done_q    <= 1'b1;
                                    chg_q     <= 2'b00;
                                end else begin
                                    rd_addr_q <= '0;
                                    chg_q     <= 2'b01;
                                end
                            end else begin
                                rd_addr_q <= rd_addr_q + AW'(1);
                                chg_q     <= 2'b01;
                            end
                        end else begin
                            div_q <= div_q + DIVW'(1);
                        end
                    end
                end

                ST_CLEAR: begin
                    // One zero word per cycle; inputs ignored until the sweep ends
                    if (wr_addr_q == C_LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wr_addr_q + AW'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Wr_En   = wr_en_q;
    assign Wr_Addr = wr_addr_q;
    assign Wr_X    = wr_x_q;
    assign Wr_Y    = wr_y_q;
    assign Rd_Addr = rd_addr_q;
    assign DC_X    = dc_x_q;
    assign DC_Y    = dc_y_q;
    assign Count   = count_q;
    assign Full    = full;
    assign Playing = playing_q;
    assign Busy    = busy_q;

endmodule
`default_nettype wire
